dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32I core: the slave end of the load/store interface that the datapath drives with an address, store data and access size. It accepts one request at a time through a valid/ready handshake and inserts a configurable number of wait states. It performs byte, halfword or word access to an internal word-organised array with per-byte write lanes. It returns sign- or zero-extended load data, or an error, through a second valid/ready handshake.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; the valid word index range is 0..DEPTH_WORDS-1.
- WAIT_STATES, 2: extra cycles between request acceptance and the access; legal range 0..15.

- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  request was misaligned, out of range or had an illegal funct3.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready=1; all other outputs are 0.
  - On req_valid&&req_ready, latch write, funct3, addr and wdata.
  - The latched request is illegal if any of the following holds:
    - funct3 is not listed above for its direction;
    - half access with addr[0]=1;
    - word access with addr[1:0]≠0;
    - addr[31:2] ≥ DEPTH_WORDS.
  - Illegal request: go to RESP with resp_error=1 and resp_rdata=0. The array is untouched.
  - Legal request with WAIT_STATES=0: perform the access on the accepting edge and go to RESP.
  - Legal request otherwise: load the counter with WAIT_STATES and go to WAIT.
- **WAIT**
  - req_ready=0.
  - If the counter equals 1, perform the access on this edge and go to RESP.
  - Otherwise decrement the counter.
- **Access**
  - Word index is addr[31:2].
  - Store write lanes:
    - SB writes lane addr[1:0] with wdata[7:0].
    - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
    - SW writes all four lanes.
    - Unselected lanes keep their value.
  - Load extraction:
    - Byte = word[8*addr[1:0] +: 8].
    - Half = word[16*addr[1] +: 16].
    - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - Load data is registered into resp_rdata at the access edge.
- **RESP**
  - resp_valid=1; resp_rdata and resp_error are held stable.
  - On resp_valid&&resp_ready, return to IDLE and clear resp_valid, resp_rdata and resp_error on that edge.
  - resp_ready is ignored outside RESP.
- There is no pipelining: at most one transaction is in flight. A new request is accepted no earlier than the cycle after the response handshake.

## Timing
- **Reset**
  - While reset=0: state IDLE, counter 0, req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0.
  - req_ready rises in the first cycle after reset is released.
  - Array contents are not cleared by reset.
- **Latency**, with the request accepted at edge N:
  - Legal request: resp_valid is first high in the cycle following edge N+WAIT_STATES.
  - Illegal request: resp_valid is first high in the cycle following edge N, regardless of WAIT_STATES.
- **Throughput**: with resp_ready held high, one legal transaction completes every WAIT_STATES+2 cycles.
- **Reset mid-operation**: reset asserted in WAIT before the access edge aborts the transaction with no array write. Reset asserted in RESP drops the response.
- **Simultaneous events**:
  - req_valid asserted during WAIT or RESP is not accepted. The requester must hold its request until req_ready=1.
  - A load from the address written by the immediately preceding store returns the new data.

## Test plan
- **Word round trip, WAIT_STATES=2**:
  - SW addr 0x10 data 0xDEADBEEF.
  - Then LW 0x10 -> resp_rdata 0xDEADBEEF, resp_error 0.
  - resp_valid first high 2 cycles after each accept edge.
- **Byte and half extension**, with word 0x10 = 0x80FF7F01:
  - LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01.
- **Partial stores**, with word 0x20 = 0x11223344:
  - SB 0x21 data 0xAB -> LW 0x20 returns 0x1122AB44.
  - SH 0x22 data 0xCDEF -> LW 0x20 returns 0xCDEFAB44.
- **Errors**:
  - LW 0x22, SH 0x05, funct3 011 and addr 4*DEPTH_WORDS each give resp_error=1 and resp_rdata=0 one cycle after accept.
  - The array is unchanged, as checked by LW afterwards.
- **Backpressure**:
  - Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready stays 0.
  - A req_valid presented in that window is accepted only after the response handshake.
- **Reset mid-operation and WAIT_STATES=0**:
  - Assert reset during WAIT of SW 0x30 data 0x12345678 -> all outputs 0 immediately; a subsequent LW 0x30 returns the old value.
  - Rerun with WAIT_STATES=0 -> resp_valid is high the cycle after accept.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the RV32I load/store unit.
// Accepts one request at a time over a valid/ready handshake, waits
// WAIT_STATES cycles, then performs a byte/half/word access to a
// word-organised array with per-byte write lanes. The response carries
// sign/zero-extended load data or an error flag.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (word index 0..DEPTH_WORDS-1)
//   WAIT_STATES  cycles between acceptance and access (0..15)
// Ports:
//   clock, reset (async, active-low)
//   req_valid/req_ready, req_write, req_funct3, req_addr, req_wdata
//   resp_valid/resp_ready, resp_rdata, resp_error
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Request fields seen by the access logic: live inputs on the accepting
  // edge (needed when WAIT_STATES=0 or for the legality check), latched
  // copies while waiting.
  logic        cur_write;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic          accept;
  logic          illegal;
  logic          do_access;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_data;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;

  // Held low while reset is asserted so nothing is accepted during reset.
  assign req_ready  = reset && (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;
  assign accept     = req_valid && req_ready;

  always_comb begin
    if (state == IDLE) begin
      cur_write  = req_write;
      cur_funct3 = req_funct3;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
    end else begin
      cur_write  = write_q;
      cur_funct3 = funct3_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
    end
  end

  always_comb begin
    illegal = 1'b0;
    if (cur_write) begin
      if (!(cur_funct3 inside {3'b000, 3'b001, 3'b010})) illegal = 1'b1;
    end else begin
      if (!(cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) illegal = 1'b1;
    end
    if (cur_funct3[1:0] == 2'b01 && cur_addr[0]) illegal = 1'b1;
    if (cur_funct3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00) illegal = 1'b1;
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) illegal = 1'b1;
  end

  assign do_access = (accept && !illegal && (WAIT_STATES == 0)) ||
                     (state == WAIT && cnt == 4'd1);

  assign word_idx = cur_addr[AW+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    case (cur_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_funct3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h000000, rd_byte};
      3'b101:  ld_data = {16'h0000, rd_half};
      default: ld_data = '0;
    endcase
  end

  // Store data is replicated across lanes so each enabled lane simply takes
  // its own byte position.
  always_comb begin
    lane_en   = '0;
    lane_data = cur_wdata;
    case (cur_funct3[1:0])
      2'b00: begin
        lane_en[cur_addr[1:0]] = 1'b1;
        lane_data              = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{cur_wdata[15:0]}};
      end
      2'b10:   lane_en = 4'b1111;
      default: lane_en = '0;
    endcase
  end

  // Array is intentionally not reset.
  always_ff @(posedge clock) begin
    if (do_access && cur_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (illegal) begin
              error_q <= 1'b1;
              rdata_q <= '0;
              state   <= RESP;
            end else if (WAIT_STATES == 0) begin
              rdata_q <= req_write ? '0 : ld_data;
              state   <= RESP;
            end else begin
              cnt   <= 4'(WAIT_STATES);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            rdata_q <= write_q ? '0 : ld_data;
            cnt     <= '0;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            rdata_q <= '0;
            error_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: one instance with WAIT_STATES=2, one with 0.
module tb_dmem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] resp_rdata [2];

  int total = 0;
  int bad   = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut_w2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_w0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  typedef struct {
    int          d;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic er, input int lat);
    vec_t v;
    v.d = d; v.w = w; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.err = er; v.lat = lat;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction; lat counts falling edges after the accept
  // edge before resp_valid is seen (0 = high in the cycle right after accept).
  task automatic txn(input int d, input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clock);
    req_valid[d] = 1'b1; req_write[d] = w; req_funct3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clock);
      n++;
    end
    check32({tag, " ready"}, 32'(req_ready[d]), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    rd = resp_rdata[d];
    er = resp_error[d];
    resp_ready[d] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready[d] = 1'b0;
    check32({tag, " cleared"}, resp_rdata[d] | 32'(resp_valid[d]) | 32'(resp_error[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    reset = 1'b0;
    req_valid = '0; req_write = '0; resp_ready = '0;
    for (int i = 0; i < 2; i++) begin
      req_funct3[i] = '0; req_addr[i] = '0; req_wdata[i] = '0;
    end

    // DUT 0, WAIT_STATES=2
    vecs.push_back(mk(0, 1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2));
    vecs.push_back(mk(0, 0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2));
    vecs.push_back(mk(0, 1, 3'b010, 32'h10,   32'h80FF7F01, 32'h0,        0, 2));
    vecs.push_back(mk(0, 0, 3'b000, 32'h13,   32'h0,        32'hFFFFFF80, 0, 2));
    vecs.push_back(mk(0, 0, 3'b100, 32'h13,   32'h0,        32'h00000080, 0, 2));
    vecs.push_back(mk(0, 0, 3'b001, 32'h12,   32'h0,        32'hFFFF80FF, 0, 2));
    vecs.push_back(mk(0, 0, 3'b101, 32'h10,   32'h0,        32'h00007F01, 0, 2));
    vecs.push_back(mk(0, 0, 3'b000, 32'h11,   32'h0,        32'h0000007F, 0, 2));
    vecs.push_back(mk(0, 0, 3'b101, 32'h12,   32'h0,        32'h000080FF, 0, 2));
    vecs.push_back(mk(0, 1, 3'b010, 32'h20,   32'h11223344, 32'h0,        0, 2));
    vecs.push_back(mk(0, 1, 3'b000, 32'h21,   32'hFFFFFFAB, 32'h0,        0, 2));
    vecs.push_back(mk(0, 0, 3'b010, 32'h20,   32'h0,        32'h1122AB44, 0, 2));
    vecs.push_back(mk(0, 1, 3'b001, 32'h22,   32'h1234CDEF, 32'h0,        0, 2));
    vecs.push_back(mk(0, 0, 3'b010, 32'h20,   32'h0,        32'hCDEFAB44, 0, 2));
    vecs.push_back(mk(0, 1, 3'b010, 32'h04,   32'h55555555, 32'h0,        0, 2));
    vecs.push_back(mk(0, 1, 3'b010, 32'h30,   32'hA5A5A5A5, 32'h0,        0, 2));
    vecs.push_back(mk(0, 0, 3'b010, 32'h22,   32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h05,   32'h0000FFFF, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h04,   32'h0,        32'h55555555, 0, 2));
    vecs.push_back(mk(0, 0, 3'b011, 32'h20,   32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 3'b011, 32'h20,   32'hFFFFFFFF, 32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h20,   32'h00000000, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h1000, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h1000, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h20,   32'h0,        32'hCDEFAB44, 0, 2));
    vecs.push_back(mk(0, 1, 3'b010, 32'hFFC,  32'hCAFEF00D, 32'h0,        0, 2));
    vecs.push_back(mk(0, 0, 3'b001, 32'hFFE,  32'h0,        32'hFFFFCAFE, 0, 2));
    vecs.push_back(mk(0, 0, 3'b010, 32'h03,   32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 3'b101, 32'h03,   32'h0,        32'h0,        1, 0));
    // DUT 1, WAIT_STATES=0
    vecs.push_back(mk(1, 1, 3'b010, 32'h40,   32'h0BADF00D, 32'h0,        0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h40,   32'h0,        32'h0BADF00D, 0, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h41,   32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 3'b000, 32'h43,   32'h0000007E, 32'h0,        0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h40,   32'h0,        32'h7EADF00D, 0, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h42,   32'h0,        32'hFFFFFFAD, 0, 0));

    // Reset state
    repeat (2) @(negedge clock);
    check32("rst req_ready",  32'(req_ready),  32'd0);
    check32("rst resp_valid", 32'(resp_valid), 32'd0);
    check32("rst resp_error", 32'(resp_error), 32'd0);
    check32("rst rdata0",     resp_rdata[0],   32'd0);
    check32("rst rdata1",     resp_rdata[1],   32'd0);
    reset = 1'b1;
    @(negedge clock);
    check32("post-rst req_ready", 32'(req_ready), 32'd3);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      txn(vecs[i].d, tag, vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check32({tag, " rdata"}, rd, vecs[i].rdata);
      check32({tag, " error"}, 32'(er), 32'(vecs[i].err));
      check32({tag, " latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: LW 0x10 stalled 5 cycles in RESP while a second request waits.
    @(negedge clock);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_funct3[0] = 3'b010; req_addr[0] = 32'h10;
    check32("bp ready", 32'(req_ready[0]), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_addr[0] = 32'h20;
    lat = 0;
    while (!resp_valid[0] && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check32("bp latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check32($sformatf("bp hold%0d rdata", i), resp_rdata[0], 32'h80FF7F01);
      check32($sformatf("bp hold%0d valid", i), 32'(resp_valid[0]), 32'd1);
      check32($sformatf("bp hold%0d req_ready", i), 32'(req_ready[0]), 32'd0);
      @(negedge clock);
    end
    resp_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready[0] = 1'b0;
    check32("bp after hs valid", 32'(resp_valid[0]), 32'd0);
    check32("bp after hs rdata", resp_rdata[0], 32'd0);
    check32("bp after hs req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    lat = 0;
    while (!resp_valid[0] && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check32("bp second latency", 32'(lat), 32'd2);
    check32("bp second rdata", resp_rdata[0], 32'hCDEFAB44);
    resp_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready[0] = 1'b0;

    // Reset during WAIT of SW 0x30 aborts the store.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_funct3[0] = 3'b010;
    req_addr[0] = 32'h30; req_wdata[0] = 32'h12345678;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    reset = 1'b0;
    #1;
    check32("midrst req_ready",  32'(req_ready[0]),  32'd0);
    check32("midrst resp_valid", 32'(resp_valid[0]), 32'd0);
    check32("midrst resp_error", 32'(resp_error[0]), 32'd0);
    check32("midrst rdata",      resp_rdata[0],      32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    txn(0, "midrst lw", 1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
    check32("midrst lw rdata", rd, 32'hA5A5A5A5);

    // Reset in RESP drops the response.
    @(negedge clock);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_funct3[0] = 3'b010; req_addr[0] = 32'h04;
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    lat = 0;
    while (!resp_valid[0] && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check32("resprst pre rdata", resp_rdata[0], 32'h55555555);
    reset = 1'b0;
    #1;
    check32("resprst valid", 32'(resp_valid[0]), 32'd0);
    check32("resprst rdata", resp_rdata[0], 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check32("resprst ready", 32'(req_ready[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
